dsp_i2s_transmitter: RTL and testbench

Serializes the stereo sample pair produced by the DSP mixer once per 64-clock sample period into a standard I2S stream (BCLK, LRCLK, SDATA) for the external audio DAC. It sits directly downstream of the DSP output latch and double-buffers samples so the DSP schedule and the serial frame are decoupled by at most one sample. It detects underrun (sample missing at a frame boundary) and overrun (two samples in one frame), and reports them as status.

---
 rtl/dsp_audio_pkg.sv | 14 +
 rtl/dsp_i2s_transmitter_if.sv | 23 ++
 rtl/dsp_i2s_transmitter.sv | 139 +++++++++++++
 tb/tb_dsp_i2s_transmitter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dsp_audio_pkg.sv
// Shared audio constants and the I2S transmitter state type used by the mixer,
// the transmitter and the I2S receiver model.
package dsp_audio_pkg;

  localparam int unsigned SAMPLE_WIDTH      = 16;
  localparam int unsigned CLOCKS_PER_SAMPLE = 4 * SAMPLE_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } i2s_state_t;

endpackage

// File: rtl/dsp_i2s_transmitter_if.sv
// Sample handoff from the DSP output latch plus the I2S serial lines to the DAC.
interface dsp_i2s_transmitter_if #(
  parameter int unsigned SAMPLE_WIDTH = dsp_audio_pkg::SAMPLE_WIDTH
);

  logic signed [SAMPLE_WIDTH-1:0] sample_l;
  logic signed [SAMPLE_WIDTH-1:0] sample_r;
  logic                           sample_valid;
  logic                           i2s_bclk;
  logic                           i2s_lrclk;
  logic                           i2s_sdata;

  modport master (
    output sample_l, sample_r, sample_valid,
    input  i2s_bclk, i2s_lrclk, i2s_sdata
  );

  modport slave (
    input  sample_l, sample_r, sample_valid,
    output i2s_bclk, i2s_lrclk, i2s_sdata
  );

endinterface

// File: rtl/dsp_i2s_transmitter.sv
// Double-buffered stereo I2S serializer: one frame of 4*SAMPLE_WIDTH clocks per
// sample pair, with underrun/overrun status.
module dsp_i2s_transmitter #(
  parameter int unsigned SAMPLE_WIDTH = dsp_audio_pkg::SAMPLE_WIDTH
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        mute,
  input  logic                        status_clear,
  dsp_i2s_transmitter_if.slave        io,
  output logic                        running,
  output logic                        overrun,
  output logic [7:0]                  underrun_count
);
  import dsp_audio_pkg::*;

  localparam int unsigned FRAME_CLKS = 4 * SAMPLE_WIDTH;
  localparam int unsigned PHASE_W    = $clog2(FRAME_CLKS);
  localparam int unsigned SLOT_W     = PHASE_W - 1;
  localparam int unsigned WORD_W     = 2 * SAMPLE_WIDTH;

  localparam logic [PHASE_W-1:0] PHASE_LAST   = PHASE_W'(FRAME_CLKS - 1);
  localparam logic [SLOT_W-1:0]  SLOT_LAST    = SLOT_W'(WORD_W - 1);
  localparam logic [SLOT_W-1:0]  LR_HIGH_FIRST = SLOT_W'(SAMPLE_WIDTH - 1);
  localparam logic [SLOT_W-1:0]  LR_HIGH_LAST  = SLOT_W'(WORD_W - 2);

  i2s_state_t          state;
  i2s_state_t          state_next;
  logic [PHASE_W-1:0]  phase;
  logic [SLOT_W-1:0]   slot;
  logic [WORD_W-1:0]   tx_word;
  logic [WORD_W-1:0]   hold_reg;
  logic [WORD_W-1:0]   sample_word;
  logic                hold_fresh;
  logic                boundary;
  logic                bclk_d;
  logic                lrclk_d;
  logic                sdata_d;

  assign slot        = phase[PHASE_W-1:1];
  assign sample_word = {io.sample_l, io.sample_r};
  assign boundary    = (state != IDLE) && (phase == PHASE_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (io.sample_valid && enable) state_next = RUN;
      RUN:     if (boundary && !enable)       state_next = DRAIN;
      DRAIN:   if (boundary)                  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // tx_word is indexed by slot instead of shifted; LRCLK leads the MSB by one slot.
  always_comb begin
    bclk_d  = 1'b0;
    lrclk_d = 1'b0;
    sdata_d = 1'b0;
    if (state != IDLE) begin
      bclk_d  = phase[0];
      lrclk_d = (slot >= LR_HIGH_FIRST) && (slot <= LR_HIGH_LAST);
      sdata_d = tx_word[SLOT_LAST - slot];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io.i2s_bclk  <= 1'b0;
      io.i2s_lrclk <= 1'b0;
      io.i2s_sdata <= 1'b0;
      running      <= 1'b0;
    end else begin
      io.i2s_bclk  <= bclk_d;
      io.i2s_lrclk <= lrclk_d;
      io.i2s_sdata <= sdata_d;
      running      <= (state_next == RUN);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase      <= '0;
      tx_word    <= '0;
      hold_reg   <= '0;
      hold_fresh <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          phase <= '0;
          if (io.sample_valid && enable) tx_word <= sample_word;
        end
        RUN: begin
          phase <= boundary ? '0 : phase + PHASE_W'(1);
          if (!boundary) begin
            if (io.sample_valid) begin
              hold_reg   <= sample_word;
              hold_fresh <= 1'b1;
            end
          end else begin
            // A boundary strobe bypasses hold_reg, so an underrun later replays
            // the last sample that went through the hold register.
            hold_fresh <= 1'b0;
            if (!enable || mute)      tx_word <= '0;
            else if (io.sample_valid) tx_word <= sample_word;
            else                      tx_word <= hold_reg;
          end
        end
        DRAIN: begin
          phase   <= boundary ? '0 : phase + PHASE_W'(1);
          tx_word <= '0;
        end
        default: phase <= '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overrun        <= 1'b0;
      underrun_count <= '0;
    end else if (status_clear) begin
      overrun        <= 1'b0;
      underrun_count <= '0;
    end else begin
      if ((state == RUN) && !boundary && io.sample_valid && hold_fresh)
        overrun <= 1'b1;
      if ((state == RUN) && boundary && enable && !io.sample_valid && !hold_fresh
          && (underrun_count != '1))
        underrun_count <= underrun_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_dsp_i2s_transmitter.sv
// Directed bench for dsp_i2s_transmitter: frames are captured one slot at a time
// and compared against hand-derived sample words and fixed BCLK/LRCLK patterns.
module tb_dsp_i2s_transmitter;
  import dsp_audio_pkg::*;

  localparam logic [31:0] LR_PATTERN   = 32'h0001_FFFE;
  localparam logic [63:0] BCLK_PATTERN = 64'hAAAA_AAAA_AAAA_AAAA;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       mute;
  logic       status_clear;
  logic       running;
  logic       overrun;
  logic [7:0] underrun_count;

  int unsigned n_checks;
  int unsigned n_pass;

  logic [31:0] cap_even;
  logic [31:0] cap_odd;
  logic [31:0] cap_lr;
  logic [63:0] cap_bclk;
  logic [31:0] prev_word;

  dsp_i2s_transmitter_if bus ();

  dsp_i2s_transmitter #(.SAMPLE_WIDTH(SAMPLE_WIDTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .mute           (mute),
    .status_clear   (status_clear),
    .io             (bus),
    .running        (running),
    .overrun        (overrun),
    .underrun_count (underrun_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] steady_word(input int unsigned i);
    logic [15:0] l;
    logic [15:0] r;
    l = 16'h1000 + 16'(i) * 16'h0123;
    r = 16'hF000 - 16'(i) * 16'h0321;
    return {l, r};
  endfunction

  // Captures one frame aligned to a boundary edge. Inputs set at the end of
  // iteration p reach the DUT on the edge of iteration p+1; p = 62 hits the boundary.
  task automatic run_frame(input string tag, input logic [31:0] exp_word,
                           input int s1, input logic [31:0] w1,
                           input int s2, input logic [31:0] w2,
                           input int clr_at, input logic mute_b, input logic en_b);
    int slot;
    for (int p = 0; p < int'(CLOCKS_PER_SAMPLE); p++) begin
      tick();
      slot = p / 2;
      if (p % 2 == 0) begin
        cap_even[31-slot] = bus.i2s_sdata;
        cap_lr[31-slot]   = bus.i2s_lrclk;
      end else begin
        cap_odd[31-slot]  = bus.i2s_sdata;
      end
      cap_bclk[p] = bus.i2s_bclk;
      bus.sample_valid = 1'b0;
      status_clear     = 1'b0;
      if (p == s1) begin
        bus.sample_valid = 1'b1;
        bus.sample_l = w1[31:16];
        bus.sample_r = w1[15:0];
      end
      if (p == s2) begin
        bus.sample_valid = 1'b1;
        bus.sample_l = w2[31:16];
        bus.sample_r = w2[15:0];
      end
      if (p == clr_at) status_clear = 1'b1;
      if (p == 62) begin
        mute   = mute_b;
        enable = en_b;
      end
      if (p == 63) begin
        mute   = 1'b0;
        enable = 1'b1;
      end
    end
    check_val($sformatf("%s data", tag), 64'(cap_even), 64'(exp_word));
    check_val($sformatf("%s hold", tag), 64'(cap_odd), 64'(exp_word));
    check_val($sformatf("%s lrclk", tag), 64'(cap_lr), 64'(LR_PATTERN));
    check_val($sformatf("%s bclk", tag), cap_bclk, BCLK_PATTERN);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b0;
    enable = 1'b1;
    mute = 1'b0;
    status_clear = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_l = '0;
    bus.sample_r = '0;

    repeat (3) tick();
    check_val("rst bclk", 64'(bus.i2s_bclk), 64'd0);
    check_val("rst lrclk", 64'(bus.i2s_lrclk), 64'd0);
    check_val("rst sdata", 64'(bus.i2s_sdata), 64'd0);
    check_val("rst running", 64'(running), 64'd0);
    check_val("rst overrun", 64'(overrun), 64'd0);
    check_val("rst underrun", 64'(underrun_count), 64'd0);

    reset = 1'b1;
    repeat (4) tick();
    check_val("idle running", 64'(running), 64'd0);
    check_val("idle bclk", 64'(bus.i2s_bclk), 64'd0);

    // First sample out of IDLE: outputs lag the accepting edge by one clock.
    bus.sample_l = 16'h8001;
    bus.sample_r = 16'h7FFE;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    check_val("start running", 64'(running), 64'd1);
    check_val("start sdata", 64'(bus.i2s_sdata), 64'd0);
    run_frame("first", 32'h8001_7FFE, 10, 32'hA5A5_5A5A, -1, '0, -1, 1'b0, 1'b1);
    prev_word = 32'hA5A5_5A5A;

    for (int unsigned i = 0; i < 100; i++) begin
      run_frame($sformatf("steady%0d", i), prev_word, 20, steady_word(i), -1, '0, -1, 1'b0, 1'b1);
      prev_word = steady_word(i);
    end
    check_val("steady running", 64'(running), 64'd1);
    check_val("steady overrun", 64'(overrun), 64'd0);
    check_val("steady underrun", 64'(underrun_count), 64'd0);

    run_frame("ur0", prev_word, 20, 32'h1234_4321, -1, '0, -1, 1'b0, 1'b1);
    for (int j = 1; j <= 300; j++) begin
      run_frame($sformatf("ur%0d", j), 32'h1234_4321, -1, '0, -1, '0, -1, 1'b0, 1'b1);
      check_val($sformatf("ur%0d count", j), 64'(underrun_count), 64'((j > 255) ? 255 : j));
    end

    run_frame("ovr1", 32'h1234_4321, 5, 32'h1111_AAAA, 30, 32'h2222_BBBB, -1, 1'b0, 1'b1);
    check_val("ovr1 overrun", 64'(overrun), 64'd1);
    check_val("ovr1 count", 64'(underrun_count), 64'd255);
    run_frame("ovr2", 32'h2222_BBBB, 62, 32'h3333_CCCC, -1, '0, -1, 1'b0, 1'b1);
    check_val("ovr2 overrun", 64'(overrun), 64'd1);
    run_frame("bypass", 32'h3333_CCCC, -1, '0, -1, '0, -1, 1'b0, 1'b1);
    run_frame("replay", 32'h2222_BBBB, 10, 32'h4444_DDDD, -1, '0, 3, 1'b0, 1'b1);
    check_val("clr overrun", 64'(overrun), 64'd0);
    check_val("clr count", 64'(underrun_count), 64'd0);
    run_frame("clrprio", 32'h4444_DDDD, 10, 32'h5555_EEEE, 20, 32'h6666_FFFF, 20, 1'b0, 1'b1);
    check_val("clrprio overrun", 64'(overrun), 64'd0);
    run_frame("latest", 32'h6666_FFFF, -1, '0, -1, '0, 62, 1'b0, 1'b1);
    check_val("clrprio count", 64'(underrun_count), 64'd0);
    run_frame("ur_after_clr", 32'h6666_FFFF, -1, '0, -1, '0, -1, 1'b0, 1'b1);
    check_val("ur_after_clr count", 64'(underrun_count), 64'd1);

    run_frame("pre_mute", 32'h6666_FFFF, 10, 32'h7777_1111, -1, '0, -1, 1'b1, 1'b1);
    run_frame("muted", 32'h0000_0000, 10, 32'h8888_2222, -1, '0, -1, 1'b0, 1'b1);
    check_val("muted count", 64'(underrun_count), 64'd1);
    run_frame("pre_drain", 32'h8888_2222, -1, '0, -1, '0, -1, 1'b0, 1'b0);
    check_val("drain running", 64'(running), 64'd0);
    run_frame("drain", 32'h0000_0000, -1, '0, -1, '0, -1, 1'b0, 1'b1);
    repeat (2) tick();
    check_val("post_drain running", 64'(running), 64'd0);
    check_val("post_drain bclk", 64'(bus.i2s_bclk), 64'd0);
    check_val("post_drain lrclk", 64'(bus.i2s_lrclk), 64'd0);
    check_val("post_drain sdata", 64'(bus.i2s_sdata), 64'd0);

    // Restart, then pull reset between clock edges while outputs are high.
    bus.sample_l = 16'hFFFF;
    bus.sample_r = 16'hFFFF;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    repeat (20) tick();
    check_val("pre_rst sdata", 64'(bus.i2s_sdata), 64'd1);
    check_val("pre_rst bclk", 64'(bus.i2s_bclk), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check_val("async bclk", 64'(bus.i2s_bclk), 64'd0);
    check_val("async lrclk", 64'(bus.i2s_lrclk), 64'd0);
    check_val("async sdata", 64'(bus.i2s_sdata), 64'd0);
    check_val("async running", 64'(running), 64'd0);
    check_val("async underrun", 64'(underrun_count), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
